// File: rtl/mac_out_packer.sv
// mac_out_packer: saturates signed MAC results to OUT_WIDTH lanes, packs LANES per word, queues words in a small FIFO.
// Optional build macro MAC_PACK_RELU_EN zeroes negative inputs before saturation.
module mac_out_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [IN_WIDTH-1:0]    in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_WIDTH-1:0]    out_data,
  output logic [$clog2(LANES+1)-1:0]    out_count,
  output logic [15:0]                   sat_count
);
  localparam int WORD_W = LANES * OUT_WIDTH;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_WIDTH-1:0] LANE_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] LANE_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [15:0]       sat_cnt_q, sat_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [WORD_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  cnt_mem_q  [FIFO_DEPTH];

  logic signed [IN_WIDTH-1:0] relu_val;
  logic [OUT_WIDTH-1:0] lane_val;
  logic                 clamped;
  logic                 xfer, word_done, pop;
  logic [WORD_W-1:0]    word_out;
  logic [CNT_W-1:0]     word_cnt;

  // Ready comes only from registered occupancy, never from the handshake inputs.
  assign in_ready  = (occ_q != OCC_W'(FIFO_DEPTH));
  assign out_valid = (occ_q != '0);
  assign xfer      = in_valid & in_ready;
  assign word_done = xfer & (in_last | (lane_q == LANE_W'(LANES - 1)));
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_count = out_valid ? cnt_mem_q[rd_ptr_q] : '0;
  assign sat_count = sat_cnt_q;

  always_comb begin
`ifdef MAC_PACK_RELU_EN
    relu_val = in_data[IN_WIDTH-1] ? '0 : in_data;
`else
    relu_val = in_data;
`endif
    clamped  = 1'b0;
    lane_val = relu_val[OUT_WIDTH-1:0];
    if (relu_val > SAT_MAX) begin
      lane_val = LANE_MAX;
      clamped  = 1'b1;
    end else if (relu_val < SAT_MIN) begin
      lane_val = LANE_MIN;
      clamped  = 1'b1;
    end
  end

  // Word as it looks with the current lane inserted; lanes above it are still zero.
  always_comb begin
    word_out = pack_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) word_out[i*OUT_WIDTH +: OUT_WIDTH] = lane_val;
    end
    word_cnt = CNT_W'(lane_q) + CNT_W'(1);
  end

  always_comb begin
    lane_d    = lane_q;
    pack_d    = pack_q;
    sat_cnt_d = sat_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    if (xfer) begin
      if (word_done) begin
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        pack_d = word_out;
      end
      if (clamped && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end
    if (word_done) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({word_done, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      lane_q    <= '0;
      pack_q    <= '0;
      sat_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        cnt_mem_q[i]  <= '0;
      end
    end else begin
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      sat_cnt_q <= sat_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      if (word_done) begin
        data_mem_q[wr_ptr_q] <= word_out;
        cnt_mem_q[wr_ptr_q]  <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mac_out_packer.sv
// Bench for mac_out_packer: directed cases plus random traffic against a queue-based reference model.
module tb_mac_out_packer;
  localparam int IW = 16;
  localparam int OW = 8;
  localparam int LN = 4;
  localparam int FD = 4;
  localparam int CW = $clog2(LN + 1);
  localparam int WW = LN * OW;

  logic                 clk = 1'b0;
  logic                 arst_n_in = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [IW-1:0] in_data = '0;
  logic                 in_ready, out_valid;
  logic [WW-1:0]        out_data;
  logic [CW-1:0]        out_count;
  logic [15:0]          sat_count;

  always #5 clk = ~clk;

  mac_out_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(LN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .sat_count(sat_count)
  );

  typedef struct { logic [WW-1:0] data; int cnt; } word_t;

  int    n_cmp = 0;
  int    n_err = 0;
  word_t exp_q[$];
  int    lane_vals[LN];
  int    lane_idx = 0;
  int    sat_ref = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat_lane(input int v, output bit clamped);
    int hi, lo;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    clamped = 1'b0;
`ifdef MAC_PACK_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > hi) begin v = hi; clamped = 1'b1; end
    else if (v < lo) begin v = lo; clamped = 1'b1; end
    return v;
  endfunction

  // One clock of traffic: checks outputs against the model, then advances both.
  task automatic step(input bit v, input int d, input bit last, input bit ordy);
    bit    m_ready, m_xfer, m_pop, cl;
    int    s;
    word_t w;
    in_valid  = v;
    in_data   = IW'(d);
    in_last   = last;
    out_ready = ordy;
    m_ready = (exp_q.size() < FD);
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0].data));
      chk("out_count", 64'(out_count), 64'(exp_q[0].cnt));
    end
    chk("sat_count", 64'(sat_count), 64'(sat_ref));
    m_xfer = v && m_ready;
    m_pop  = ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (m_pop) void'(exp_q.pop_front());
    if (m_xfer) begin
      s = sat_lane(d, cl);
      if (cl && sat_ref < 65535) sat_ref++;
      lane_vals[lane_idx] = s;
      lane_idx++;
      if (last || lane_idx == LN) begin
        w.data = '0;
        for (int i = 0; i < lane_idx; i++)
          w.data = w.data | (WW'(lane_vals[i] & ((1 << OW) - 1)) << (i * OW));
        w.cnt = lane_idx;
        exp_q.push_back(w);
        lane_idx = 0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    arst_n_in = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    exp_q.delete();
    lane_idx = 0;
    sat_ref  = 0;
    #2;
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    #2;
    apply_reset();

    // Simple four-lane pack
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1); step(1, 4, 0, 1);
    chk("pack_valid", 64'(out_valid), 64'd1);
    chk("pack_data", 64'(out_data), 64'h04030201);
    chk("pack_count", 64'(out_count), 64'd4);
    step(0, 0, 0, 1);

    apply_reset();
    step(1, 300, 0, 1); step(1, -300, 0, 1); step(1, 127, 0, 1); step(1, -128, 0, 1);
`ifndef MAC_PACK_RELU_EN
    chk("sat_data", 64'(out_data), 64'h807F807F);
    chk("sat_count_2", 64'(sat_count), 64'd2);
`endif
    step(0, 0, 0, 1);

    // Short word closed by in_last, then next word restarts at lane 0
    apply_reset();
    step(1, 5, 0, 1); step(1, 6, 1, 1);
    chk("last_data", 64'(out_data), 64'h00000605);
    chk("last_count", 64'(out_count), 64'd2);
    step(1, 7, 0, 1); step(1, 8, 0, 1); step(1, 9, 0, 1); step(1, 10, 0, 1);
    chk("after_last_data", 64'(out_data), 64'h0A090807);
    step(0, 0, 0, 1);

    // Backpressure: fill the FIFO, then drain in order
    apply_reset();
    for (int i = 0; i < 4 * LN; i++) step(1, i + 1, 0, 0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(out_data), 64'h04030201);
    step(1, 99, 0, 0);
    for (int i = 0; i < 2 * FD && exp_q.size() > 0; i++) step(0, 0, 0, 1);
    chk("drained_in_ready", 64'(in_ready), 64'd1);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Reset with one queued word and a partial word
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    step(1, 5, 0, 0); step(1, 6, 0, 0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    apply_reset();
    step(1, 9, 0, 1); step(1, 10, 0, 1); step(1, 11, 0, 1); step(1, 12, 0, 1);
    chk("post_rst_data", 64'(out_data), 64'h0C0B0A09);
    step(0, 0, 0, 1);

`ifdef MAC_PACK_RELU_EN
    apply_reset();
    step(1, -5, 0, 1); step(1, 3, 0, 1); step(1, -300, 0, 1); step(1, 200, 0, 1);
    chk("relu_data", 64'(out_data), 64'h7F000300);
    chk("relu_sat", 64'(sat_count), 64'd1);
    step(0, 0, 0, 1);
`endif

    // Random traffic with mixed backpressure
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 511)) - 256;
      else                           d = int'($urandom_range(0, 65535)) - 32768;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 2 * FD && exp_q.size() > 0; i++) step(0, 0, 0, 1);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
